reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter SP_INIT, default 32'h0000_0FFC: value loaded into x2 (sp) by the clear sequence.
REQ-002 The block SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding enabled; 0 = disabled.
REQ-003 The block SHALL have port CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port RS1_ADDR  input  5  source register 1 index.
REQ-006 The block SHALL have port RS2_ADDR  input  5  source register 2 index.
REQ-007 The block SHALL have port RD_ADDR  input  5  destination register index.
REQ-008 The block SHALL have port RD_WRITE_EN  input  1  write request for RD_ADDR.
REQ-009 The block SHALL have port RD_DATA  input  32  write data.
REQ-010 The block SHALL have port REG_READ1  output  32  rs1 read data; feeds the ALU operand-A path.
REQ-011 The block SHALL have port REG_READ2  output  32  rs2 read data; feeds the ALU operand-B select mux (REG_READ input) and store data.
REQ-012 The block SHALL have port REG_BUSY  output  1  high while the clear sequence runs; the core SHALL stall while it is high.

Function
REQ-013 Storage SHALL be 31 writable 32-bit registers x1..x31; x0 SHALL read 0 always and SHALL never be written.
REQ-014 Reads SHALL be combinational (zero latency) from RS1_ADDR/RS2_ADDR.
REQ-015 FSM states SHALL be CLEAR and RUN; a 5-bit clear counter CNT SHALL index the register being cleared.
REQ-016 In CLEAR, each rising edge SHALL write reg[CNT] <= (CNT==2 ? SP_INIT : 0) and increment CNT; at the edge where CNT==31 the state SHALL move to RUN.
REQ-017 In CLEAR, REG_BUSY SHALL be 1, REG_READ1/REG_READ2 SHALL be 0, and RD_WRITE_EN SHALL be ignored (write dropped, not queued).
REQ-018 In RUN, REG_BUSY SHALL be 0; a rising edge with RD_WRITE_EN=1 and RD_ADDR!=0 SHALL write RD_DATA to reg[RD_ADDR].
REQ-019 With BYPASS=1 in RUN, if RD_WRITE_EN=1, RD_ADDR!=0 and RD_ADDR equals RSn_ADDR, REG_READn SHALL equal RD_DATA in the same cycle; both ports SHALL forward independently.
REQ-020 With BYPASS=0, a read of the register being written SHALL return the old value until after the edge.
REQ-021 A write to x0 SHALL have no effect and SHALL NOT be forwarded; a read of x0 SHALL return 0 for any RD_DATA.
REQ-022 Exactly one write per cycle SHALL be supported; the two reads SHALL be independent, including when RS1_ADDR==RS2_ADDR.
REQ-023 CNT SHALL NOT wrap into a second clear pass; RUN SHALL persist until the next RST.

Reset
REQ-024 A rising edge with RST=1 SHALL set state=CLEAR, CNT=0 and REG_BUSY=1; RST has priority over all writes.
REQ-025 Register contents SHALL be defined only by the clear sequence, not by the reset edge itself.
REQ-026 REG_BUSY SHALL deassert exactly 32 rising edges after the last edge sampled with RST=1.
REQ-027 RST asserted mid-CLEAR SHALL restart the sequence at CNT=0.
REQ-028 RST asserted in RUN SHALL discard any same-edge write and restart the clear.

Verification
REQ-029 Reset clear: hold RST 2 cycles, release, drive RD_WRITE_EN=1, RD_ADDR=5, RD_DATA=32'hDEAD_BEEF throughout CLEAR -> REG_BUSY high for exactly 32 edges; afterwards x5=0, x2=32'h0000_0FFC, all others 0.
REQ-030 Write/read: in RUN write x7=32'h1234_5678, next cycle RS1_ADDR=7, RS2_ADDR=7 -> both outputs 32'h1234_5678.
REQ-031 Bypass: BYPASS=1, same cycle RD_ADDR=9, RD_DATA=32'hA5A5_0001, RS2_ADDR=9 (x9 previously 0) -> REG_READ2=32'hA5A5_0001 before the edge; with BYPASS=0 -> 0 before the edge, 32'hA5A5_0001 after.
REQ-032 x0: write RD_ADDR=0, RD_DATA=32'hFFFF_FFFF, read RS1_ADDR=0 same and next cycle -> REG_READ1=0 both cycles.
REQ-033 Mid-clear reset: assert RST 1 cycle at clear edge 10 -> REG_BUSY remains high for 32 further edges; final contents as REQ-029.
REQ-034 Reset in RUN: with x3=32'h55 and a write x4=32'h66 on the RST edge -> after re-clear x3=0, x4=0, x2=SP_INIT.

Source files
------------

// File: rtl/reg_file.sv
// 32 x 32-bit register file with x0 hard-wired to zero, a post-reset clear
// sequence that seeds the stack pointer, and optional write-to-read forwarding.
module reg_file #(
  parameter logic [31:0] SP_INIT = 32'h0000_0FFC,
  parameter logic        BYPASS  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  RS1_ADDR,
  input  logic [4:0]  RS2_ADDR,
  input  logic [4:0]  RD_ADDR,
  input  logic        RD_WRITE_EN,
  input  logic [31:0] RD_DATA,
  output logic [31:0] REG_READ1,
  output logic [31:0] REG_READ2,
  output logic        REG_BUSY
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] regs [0:31];

  // The reset edge only restarts the clear walk; storage is initialised by
  // the walk itself, one register per edge, so reset never touches regs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= CLEAR;
      cnt      <= 5'd0;
      REG_BUSY <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (cnt != 5'd0)
            regs[cnt] <= (cnt == 5'd2) ? SP_INIT : 32'h0;
          if (cnt == 5'd31) begin
            state    <= RUN;
            REG_BUSY <= 1'b0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        RUN: begin
          if (RD_WRITE_EN && (RD_ADDR != 5'd0))
            regs[RD_ADDR] <= RD_DATA;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    logic [31:0] value;
    value = 32'h0;
    if ((state == RUN) && (addr != 5'd0)) begin
      if (BYPASS && RD_WRITE_EN && (RD_ADDR == addr))
        value = RD_DATA;
      else
        value = regs[addr];
    end
    return value;
  endfunction

  always_comb begin
    REG_READ1 = read_port(RS1_ADDR);
    REG_READ2 = read_port(RS2_ADDR);
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: runs a forwarding and a non-forwarding instance
// side by side on the same stimulus and checks both against hand-computed values.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic        rd_write_en;
  logic [31:0] rd_data;
  logic [31:0] read1;
  logic [31:0] read2;
  logic        busy;
  logic [31:0] read1_nb;
  logic [31:0] read2_nb;
  logic        busy_nb;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] SP = 32'h0000_0FFC;

  reg_file #(.SP_INIT(SP), .BYPASS(1'b1)) dut (
    .CLK(clk), .RST(rst), .RS1_ADDR(rs1_addr), .RS2_ADDR(rs2_addr),
    .RD_ADDR(rd_addr), .RD_WRITE_EN(rd_write_en), .RD_DATA(rd_data),
    .REG_READ1(read1), .REG_READ2(read2), .REG_BUSY(busy)
  );

  reg_file #(.SP_INIT(SP), .BYPASS(1'b0)) dut_nb (
    .CLK(clk), .RST(rst), .RS1_ADDR(rs1_addr), .RS2_ADDR(rs2_addr),
    .RD_ADDR(rd_addr), .RD_WRITE_EN(rd_write_en), .RD_DATA(rd_data),
    .REG_READ1(read1_nb), .REG_READ2(read2_nb), .REG_BUSY(busy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] exp1_nb;
    logic [31:0] exp2_nb;
  } vec_t;

  vec_t vecs [10];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic we, input logic [4:0] rd,
                                input logic [31:0] data, input logic [4:0] rs1,
                                input logic [4:0] rs2);
    rd_write_en = we;
    rd_addr     = rd;
    rd_data     = data;
    rs1_addr    = rs1;
    rs2_addr    = rs2;
    #1;
  endtask

  // Counts edges until both instances leave CLEAR; inputs are left as driven.
  task automatic count_clear(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((busy || busy_nb) && n < 64);
    check_output({name, "_busy_edges"}, 32'(n), 32'd32);
    check_output({name, "_busy_nb"}, {31'h0, busy_nb}, 32'h0);
  endtask

  task automatic check_cleared(input string name);
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check_output($sformatf("%s_x%0d", name, i), read1, (i == 2) ? SP : 32'h0);
      check_output($sformatf("%s_nb_x%0d", name, 31 - i), read2_nb,
                   (31 - i == 2) ? SP : 32'h0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd7,
                32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
    vecs[2] = '{1'b1, 5'd9, 32'hA5A5_0001, 5'd1, 5'd9, 32'h0, 32'hA5A5_0001, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd2, 32'hA5A5_0001, SP, 32'hA5A5_0001, SP};
    vecs[4] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd7, 32'h0, 32'h1234_5678, 32'h0, 32'h1234_5678};
    vecs[6] = '{1'b1, 5'd3, 32'h55, 5'd3, 5'd3, 32'h55, 32'h55, 32'h0, 32'h0};
    vecs[7] = '{1'b1, 5'd4, 32'h66, 5'd3, 5'd4, 32'h55, 32'h66, 32'h55, 32'h0};
    vecs[8] = '{1'b1, 5'd3, 32'h77, 5'd3, 5'd4, 32'h77, 32'h66, 32'h55, 32'h66};
    vecs[9] = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 32'h77, 32'h66, 32'h77, 32'h66};

    // Power-up clear with a write request held on x5 the whole time.
    rst = 1'b1;
    apply_stimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd2, 5'd5);
    tick();
    tick();
    check_output("reset_busy", {31'h0, busy}, 32'h1);
    check_output("clear_read1_zero", read1, 32'h0);
    check_output("clear_read2_zero", read2, 32'h0);
    rst = 1'b0;
    count_clear("init");
    check_cleared("init");

    // Main read/write/forwarding vectors in RUN.
    for (int v = 0; v < 10; v++) begin
      apply_stimulus(vecs[v].we, vecs[v].rd, vecs[v].data, vecs[v].rs1, vecs[v].rs2);
      check_output($sformatf("vec%0d_read1", v), read1, vecs[v].exp1);
      check_output($sformatf("vec%0d_read2", v), read2, vecs[v].exp2);
      check_output($sformatf("vec%0d_nb_read1", v), read1_nb, vecs[v].exp1_nb);
      check_output($sformatf("vec%0d_nb_read2", v), read2_nb, vecs[v].exp2_nb);
      check_output($sformatf("vec%0d_busy", v), {31'h0, busy}, 32'h0);
      tick();
    end

    // Reset ten edges into a clear restarts the walk from CNT=0.
    rst = 1'b1;
    apply_stimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_output("midclear_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    apply_stimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
    count_clear("midclear");
    check_cleared("midclear");

    // Reset in RUN drops the same-edge write and re-clears everything.
    apply_stimulus(1'b1, 5'd3, 32'h55, 5'd0, 5'd0);
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    check_output("run_x3_written", read1, 32'h55);
    rst = 1'b1;
    apply_stimulus(1'b1, 5'd4, 32'h66, 5'd4, 5'd3);
    tick();
    rst = 1'b0;
    check_output("runrst_busy", {31'h0, busy}, 32'h1);
    count_clear("runrst");
    apply_stimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    check_output("runrst_x3", read1, 32'h0);
    check_output("runrst_x4", read2, 32'h0);
    apply_stimulus(1'b0, 5'd0, 32'h0, 5'd2, 5'd2);
    check_output("runrst_x2", read1, SP);
    check_output("runrst_nb_x2", read2_nb, SP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
